// File: rtl/debug_trace_pkg.sv
// rtl/debug_trace_pkg.sv - shared types, constants and helpers for the commit-trace serialiser
package debug_trace_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_PC    = 2'd1,
    MODE_INSTR = 2'd2,
    MODE_WDATA = 2'd3
  } trace_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  localparam logic [15:0] DROP_MARK_HDR = 16'hDEAD;
  localparam int          DROP_CNT_W    = 16;

  function automatic logic [DROP_CNT_W-1:0] sat_add16(input logic [DROP_CNT_W-1:0] a,
                                                      input logic [DROP_CNT_W-1:0] b);
    logic [DROP_CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : s[DROP_CNT_W-1:0];
  endfunction

  function automatic logic [31:0] field_sel(input trace_mode_e m, input logic [31:0] pc,
                                            input logic [31:0] instr, input logic [31:0] wdata);
    case (m)
      MODE_PC:    return pc;
      MODE_INSTR: return instr;
      MODE_WDATA: return wdata;
      default:    return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/debug_trace_out_if.sv
// rtl/debug_trace_out_if.sv - beat stream from the trace serialiser to the pin sink
interface debug_trace_out_if #(parameter int OUT_W = 4);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_sync;
  logic             out_ready;

  modport master (output out_data, output out_valid, output out_sync, input out_ready);
  modport slave  (input out_data, input out_valid, input out_sync, output out_ready);
endinterface

// File: rtl/trace_mfifo.sv
// rtl/trace_mfifo.sv - NW-write / 1-read word FIFO; enabled write ports land in ascending order
module trace_mfifo #(
  parameter int NW    = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NW-1:0]            wr_en_i,
  input  logic [NW*32-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [31:0]              rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   free_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] n_wr;
  logic [AW-1:0] wr_idx [NW];

  // Each enabled port takes the slot after the previously enabled ones.
  always_comb begin
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NW; i++) begin
      wr_idx[i] = wr_ptr_q + n[AW-1:0];
      n = n + {{(CW-1){1'b0}}, wr_en_i[i]};
    end
    n_wr = n;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NW; i++) begin
      if (wr_en_i[i]) mem_q[wr_idx[i]] <= wr_data_i[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + n_wr[AW-1:0];
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_q + n_wr - {{(CW-1){1'b0}}, pop_i};
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign free_o    = CW'(DEPTH) - count_q;
endmodule

// File: rtl/debug_trace_out.sv
// rtl/debug_trace_out.sv - multi-lane commit-trace capture and beat serialiser
// Optional drop-marker frames: define DEBUG_TRACE_DROP_MARK_EN.
module debug_trace_out
  import debug_trace_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8,
  parameter int OUT_W    = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CHANNELS-1:0]   commit_valid,
  input  logic [CHANNELS*32-1:0] commit_pc,
  input  logic [CHANNELS*32-1:0] commit_instr,
  input  logic [CHANNELS*32-1:0] commit_wdata,
  input  logic [1:0]            mode,
  debug_trace_out_if.master     trace,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int BEATS = 32 / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
`ifdef DEBUG_TRACE_DROP_MARK_EN
  localparam int MARK = 1;
`else
  localparam int MARK = 0;
`endif
  localparam int NW = CHANNELS + MARK;

  trace_mode_e           mode_e;
  logic [CW-1:0]         count, free, left;
  logic [NW-1:0]         wr_en;
  logic [NW*32-1:0]      wr_data;
  logic [31:0]           fifo_rd;
  logic                  pop;
  logic [DROP_CNT_W-1:0] n_drop, drop_cnt_q;
  ser_state_e            state_q;
  logic [31:0]           shreg_q;
  logic [BW-1:0]         beat_q;
  logic                  sync_q;
`ifdef DEBUG_TRACE_DROP_MARK_EN
  logic                  mark_wr;
  logic [DROP_CNT_W-1:0] mark_cnt_q;
`endif

  assign mode_e = trace_mode_e'(mode);

  // Admission uses free space from cycle start; a same-cycle pop does not help.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    n_drop  = '0;
    left    = free;
`ifdef DEBUG_TRACE_DROP_MARK_EN
    mark_wr = 1'b0;
    if (mode_e != MODE_OFF && |commit_valid && mark_cnt_q != '0 && free != '0) begin
      mark_wr = 1'b1;
      left    = left - CW'(1);
    end
    wr_en[0]       = mark_wr;
    wr_data[31:0]  = {DROP_MARK_HDR, mark_cnt_q};
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      if (commit_valid[i] && mode_e != MODE_OFF) begin
        if (left != '0) begin
          wr_en[i+MARK]              = 1'b1;
          wr_data[(i+MARK)*32 +: 32] = field_sel(mode_e, commit_pc[i*32 +: 32],
                                                 commit_instr[i*32 +: 32],
                                                 commit_wdata[i*32 +: 32]);
          left = left - CW'(1);
        end else begin
          n_drop = n_drop + DROP_CNT_W'(1);
        end
      end
    end
  end

  trace_mfifo #(.NW(NW), .DEPTH(DEPTH)) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .pop_i     (pop),
    .rd_data_o (fifo_rd),
    .count_o   (count),
    .free_o    (free)
  );

  assign pop = (count != '0) && ((state_q == IDLE) || (trace.out_ready && beat_q == LAST));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      beat_q     <= '0;
      sync_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= sat_add16(drop_cnt_q, n_drop);
      case (state_q)
        IDLE: begin
          if (pop) begin
            shreg_q <= fifo_rd;
            beat_q  <= '0;
            sync_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (trace.out_ready) begin
            if (beat_q == LAST) begin
              if (pop) begin
                shreg_q <= fifo_rd;
                beat_q  <= '0;
                sync_q  <= 1'b1;
              end else begin
                shreg_q <= '0;
                sync_q  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              shreg_q <= shreg_q << OUT_W;
              beat_q  <= beat_q + BW'(1);
              sync_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DEBUG_TRACE_DROP_MARK_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) mark_cnt_q <= '0;
    else          mark_cnt_q <= sat_add16(mark_wr ? '0 : mark_cnt_q, n_drop);
  end
`endif

  assign trace.out_valid = (state_q == SEND);
  assign trace.out_sync  = sync_q;
  assign trace.out_data  = shreg_q[31 -: OUT_W];
  assign drop_cnt        = drop_cnt_q;
endmodule
